// File: rtl/systolic_pkg.sv
// Shared types, default widths and the saturating-add helper for the systolic PE family.
package systolic_pkg;

    typedef enum logic {
        PE_MODE_WS = 1'b0,
        PE_MODE_OS = 1'b1
    } pe_mode_e;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int WEIGHT_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF    = 32;
    localparam int SAT_CALC_WIDTH   = 64;

    typedef struct packed {
        logic                               ovf;
        logic signed [SAT_CALC_WIDTH-1:0]   sum;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to a signed range
    // of 'width' bits; ovf flags that the clamp was applied.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_CALC_WIDTH-1:0] a,
        input logic signed [SAT_CALC_WIDTH-1:0] b,
        input int                               width
    );
        logic signed [SAT_CALC_WIDTH-1:0] s;
        logic signed [SAT_CALC_WIDTH-1:0] hi;
        logic signed [SAT_CALC_WIDTH-1:0] lo;
        sat_res_t                         r;
        s  = a + b;
        hi = (SAT_CALC_WIDTH'(64'sd1) <<< (width - 1)) - SAT_CALC_WIDTH'(64'sd1);
        lo = -(SAT_CALC_WIDTH'(64'sd1) <<< (width - 1));
        r.ovf = 1'b0;
        r.sum = s;
        if (s > hi) begin
            r.ovf = 1'b1;
            r.sum = hi;
        end else if (s < lo) begin
            r.ovf = 1'b1;
            r.sum = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_weight_buf.sv
// Double-buffered stationary weight: shadow register on the per-column load chain,
// active register updated from the shadow on swap.
module pe_weight_buf #(
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WEIGHT_WIDTH-1:0] din,
    input  logic                    load,
    input  logic                    swap,
    output logic [WEIGHT_WIDTH-1:0] shadow,
    output logic                    load_fwd,
    output logic [WEIGHT_WIDTH-1:0] active
);

    // Chain shift and swap; swap samples the pre-load shadow because both update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            load_fwd <= 1'b0;
            active   <= '0;
        end else if (en) begin
            load_fwd <= load;
            if (load) begin
                shadow <= din;
            end
            if (swap) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/mac_pe_ws.sv
// Systolic MAC processing element with double-buffered stationary weight.
// Modes: weight-stationary psum chain, or output-stationary local accumulate with drain.
// Optional feature macro MAC_PE_SAT_EN: saturating sums plus sticky sat_o flag.
module mac_pe_ws
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int PIPE_MULT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    data_valid_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    data_valid_o,
    input  logic [WEIGHT_WIDTH-1:0] weight_i,
    input  logic                    weight_load_i,
    output logic [WEIGHT_WIDTH-1:0] weight_o,
    output logic                    weight_load_o,
    input  logic                    weight_swap_i,
    input  logic [ACC_WIDTH-1:0]    psum_i,
    output logic [ACC_WIDTH-1:0]    psum_o,
    output logic                    psum_valid_o,
    input  logic                    acc_clear_i,
`ifdef MAC_PE_SAT_EN
    output logic                    sat_o,
`endif
    input  logic                    drain_i
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    pe_mode_e                       mode;
    logic [WEIGHT_WIDTH-1:0]        active;
    logic signed [PROD_WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    p;
    logic                           p_valid;
    logic signed [ACC_WIDTH-1:0]    acc_reg;
    logic signed [ACC_WIDTH-1:0]    addend;
    logic signed [ACC_WIDTH-1:0]    sum;

    assign mode = pe_mode_e'(mode_i);

    pe_weight_buf #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_weight_buf (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (weight_i),
        .load     (weight_load_i),
        .swap     (weight_swap_i),
        .shadow   (weight_o),
        .load_fwd (weight_load_o),
        .active   (active)
    );

    // Full-precision signed product, then sign-extended to the accumulator width.
    assign prod     = PROD_WIDTH'($signed(data_i)) * PROD_WIDTH'($signed(active));
    assign prod_ext = ACC_WIDTH'(prod);

    generate
        if (PIPE_MULT != 0) begin : g_pipe
            logic signed [ACC_WIDTH-1:0] p_reg;
            logic                        p_valid_reg;

            // Optional product register stage; adds one cycle of psum latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_reg       <= '0;
                    p_valid_reg <= 1'b0;
                end else if (en) begin
                    p_reg       <= prod_ext;
                    p_valid_reg <= data_valid_i;
                end
            end

            assign p       = p_reg;
            assign p_valid = p_valid_reg;
        end else begin : g_comb
            assign p       = prod_ext;
            assign p_valid = data_valid_i;
        end
    endgenerate

    // WS adds onto the incoming psum; OS adds onto the local accumulator (or zero on clear).
    always_comb begin
        addend = $signed(psum_i);
        if (mode == PE_MODE_OS) begin
            addend = acc_clear_i ? '0 : acc_reg;
        end
    end

`ifdef MAC_PE_SAT_EN
    sat_res_t sat_res;
    logic     ovf;

    // Sum formed wide and clamped to the signed accumulator range.
    always_comb begin
        sat_res = sat_add(SAT_CALC_WIDTH'(addend), SAT_CALC_WIDTH'(p), ACC_WIDTH);
        sum     = sat_res.sum[ACC_WIDTH-1:0];
        ovf     = sat_res.ovf;
    end

    // Sticky saturation flag; an OS clear starts a fresh accumulation and clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_o <= 1'b0;
        end else if (en) begin
            if (p_valid && ovf) begin
                sat_o <= 1'b1;
            end else if (mode == PE_MODE_OS && acc_clear_i) begin
                sat_o <= 1'b0;
            end
        end
    end
`else
    // Two's-complement wrap: truncating the sum to the accumulator width.
    assign sum = addend + p;
`endif

    // Activation forwarding, psum/accumulator update and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            psum_o       <= '0;
            psum_valid_o <= 1'b0;
            acc_reg      <= '0;
        end else if (en) begin
            data_o       <= data_i;
            data_valid_o <= data_valid_i;
            if (mode == PE_MODE_WS) begin
                psum_valid_o <= p_valid;
                if (p_valid) begin
                    psum_o <= sum;
                end
            end else begin
                if (p_valid) begin
                    acc_reg <= sum;
                end else if (acc_clear_i) begin
                    acc_reg <= '0;
                end
                psum_valid_o <= drain_i;
                if (drain_i) begin
                    psum_o <= acc_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_ws.sv
// Self-checking bench for mac_pe_ws (ACC_WIDTH=16, PIPE_MULT=0): directed steps
// followed by randomized WS and OS phases against an arithmetic reference model.
module tb_mac_pe_ws;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b1;
    logic                 mode_i = 1'b0;
    logic [DW-1:0]        data_i = '0;
    logic                 data_valid_i = 1'b0;
    logic signed [DW-1:0] data_o;
    logic                 data_valid_o;
    logic [WW-1:0]        weight_i = '0;
    logic                 weight_load_i = 1'b0;
    logic signed [WW-1:0] weight_o;
    logic                 weight_load_o;
    logic                 weight_swap_i = 1'b0;
    logic [AW-1:0]        psum_i = '0;
    logic signed [AW-1:0] psum_o;
    logic                 psum_valid_o;
    logic                 acc_clear_i = 1'b0;
    logic                 drain_i = 1'b0;
`ifdef MAC_PE_SAT_EN
    logic                 sat_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_pe_ws #(
        .DATA_WIDTH   (DW),
        .WEIGHT_WIDTH (WW),
        .ACC_WIDTH    (AW),
        .PIPE_MULT    (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mode_i        (mode_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .weight_i      (weight_i),
        .weight_load_i (weight_load_i),
        .weight_o      (weight_o),
        .weight_load_o (weight_load_o),
        .weight_swap_i (weight_swap_i),
        .psum_i        (psum_i),
        .psum_o        (psum_o),
        .psum_valid_o  (psum_valid_o),
        .acc_clear_i   (acc_clear_i),
`ifdef MAC_PE_SAT_EN
        .sat_o         (sat_o),
`endif
        .drain_i       (drain_i)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("t=%0t %s observed=%0d expected=%0d", $time, tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_valid_i  = 1'b0;
        weight_load_i = 1'b0;
        weight_swap_i = 1'b0;
        acc_clear_i   = 1'b0;
        drain_i       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Result of an ACC_WIDTH-bit sum: wrap, or clamp when saturation is built in.
    function automatic longint fit(input longint x);
`ifdef MAC_PE_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
`else
        logic signed [AW-1:0] t;
        t = x[AW-1:0];
        return longint'(t);
`endif
    endfunction

    int     m_sh, m_act, m_acc, d, w, p;
    bit     ld, sw, v, clr, dr;
    longint exp_ps;
    bit     exp_v;

    initial begin
        // Reset state
        #2;
        chk("rst_psum", psum_o, 0);
        chk("rst_psum_valid", psum_valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_weight", weight_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Weight chain + swap: MAC in the swap cycle uses the old active (0)
        weight_i = 8'd3; weight_load_i = 1'b1; step();
        chk("chain_w3", weight_o, 3);
        chk("chain_ld_fwd", weight_load_o, 1);
        weight_i = 8'd5; step();
        chk("chain_w5", weight_o, 5);
        weight_load_i = 1'b0; weight_swap_i = 1'b1;
        data_i = 8'd4; data_valid_i = 1'b1; psum_i = '0; step();
        chk("swap_cycle_psum", psum_o, 0);
        chk("swap_cycle_valid", psum_valid_o, 1);
        weight_swap_i = 1'b0; step();
        chk("after_swap_psum", psum_o, 20);

        // WS basic
        idle(); weight_i = 8'(-3); weight_load_i = 1'b1; step();
        weight_load_i = 1'b0; weight_swap_i = 1'b1; step();
        weight_swap_i = 1'b0; data_i = 8'd7; psum_i = 16'd100; data_valid_i = 1'b1; step();
        chk("ws_psum", psum_o, 79);
        chk("ws_valid", psum_valid_o, 1);
        chk("ws_data_fwd", data_o, 7);
        chk("ws_dvalid_fwd", data_valid_o, 1);
        idle(); step();
        chk("ws_valid_drop", psum_valid_o, 0);
        chk("ws_psum_hold", psum_o, 79);

        // OS accumulate and drain
        weight_i = 8'd2; weight_load_i = 1'b1; step();
        weight_load_i = 1'b0; weight_swap_i = 1'b1; step();
        weight_swap_i = 1'b0; mode_i = 1'b1;
        data_valid_i = 1'b1; acc_clear_i = 1'b1; data_i = 8'd1; step();
        acc_clear_i = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            data_i = 8'(i); step();
        end
        chk("os_no_valid", psum_valid_o, 0);
        data_valid_i = 1'b0; drain_i = 1'b1; step();
        chk("os_drain", psum_o, 20);
        chk("os_drain_valid", psum_valid_o, 1);
        data_valid_i = 1'b1; data_i = 8'd5; step();
        chk("os_drain_acc_same", psum_o, 20);
        data_valid_i = 1'b0; step();
        chk("os_drain_later", psum_o, 30);
        drain_i = 1'b0; step();
        chk("os_drain_done", psum_valid_o, 0);

        // Overflow at the accumulator width
        mode_i = 1'b0; weight_i = 8'd1; weight_load_i = 1'b1; step();
        weight_load_i = 1'b0; weight_swap_i = 1'b1; step();
        weight_swap_i = 1'b0; psum_i = 16'd32760; data_i = 8'd127; data_valid_i = 1'b1; step();
`ifdef MAC_PE_SAT_EN
        chk("ovf_psum", psum_o, 32767);
        chk("ovf_sat", sat_o, 1);
        idle(); mode_i = 1'b1; acc_clear_i = 1'b1; step();
        chk("sat_clear", sat_o, 0);
        mode_i = 1'b0;
`else
        chk("ovf_psum", psum_o, -32649);
`endif

        // Stall mid-stream
        idle(); psum_i = '0; data_i = 8'd10; data_valid_i = 1'b1; step();
        chk("stall_pre", psum_o, 10);
        en = 1'b0; data_i = 8'd20;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_psum", psum_o, 10);
            chk("stall_valid", psum_valid_o, 1);
            chk("stall_data", data_o, 10);
        end
        en = 1'b1; step();
        chk("stall_resume_psum", psum_o, 20);
        chk("stall_resume_data", data_o, 20);
        idle(); step();
        chk("stall_resume_drop", psum_valid_o, 0);

        // Randomized WS: loads, swaps (incl. load+swap together) and MACs
        do_reset();
        m_sh = 0; m_act = 0; exp_ps = 0;
        for (int i = 0; i < 40; i++) begin
            ld = ($urandom % 2) == 1;
            sw = ($urandom % 4) == 0;
            v  = ($urandom % 4) != 0;
            d  = int'($urandom_range(0, 255)) - 128;
            w  = int'($urandom_range(0, 255)) - 128;
            p  = int'($urandom_range(0, 65535)) - 32768;
            weight_i = 8'(w); weight_load_i = ld; weight_swap_i = sw;
            data_i = 8'(d); data_valid_i = v; psum_i = 16'(p);
            step();
            if (v) exp_ps = fit(longint'(p) + longint'(d) * longint'(m_act));
            if (sw) m_act = m_sh;
            if (ld) m_sh = w;
            chk("ws_rnd_valid", psum_valid_o, v);
            chk("ws_rnd_psum", psum_o, exp_ps);
            chk("ws_rnd_weight", weight_o, m_sh);
        end

        // Randomized OS with a fixed active weight
        idle(); w = int'($urandom_range(0, 255)) - 128;
        weight_i = 8'(w); weight_load_i = 1'b1; step();
        weight_load_i = 1'b0; weight_swap_i = 1'b1; step();
        idle(); mode_i = 1'b1; m_acc = 0;
        for (int i = 0; i < 40; i++) begin
            v   = (i == 0) || (($urandom % 4) != 0);
            clr = (i == 0) || (($urandom % 8) == 0);
            dr  = ($urandom % 3) == 0;
            d   = int'($urandom_range(0, 255)) - 128;
            data_i = 8'(d); data_valid_i = v; acc_clear_i = clr; drain_i = dr;
            psum_i = 16'($urandom);
            step();
            exp_v = dr;
            if (dr) exp_ps = m_acc;
            if (v) m_acc = int'(fit((clr ? 0 : longint'(m_acc)) + longint'(d) * longint'(w)));
            else if (clr) m_acc = 0;
            chk("os_rnd_valid", psum_valid_o, exp_v);
            chk("os_rnd_psum", psum_o, exp_ps);
        end

        // Asynchronous reset mid-accumulate
        idle(); data_i = 8'd9; data_valid_i = 1'b1; step();
        #2 rst = 1'b1;
        #1;
        chk("arst_psum", psum_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_dvalid", data_valid_o, 0);
        chk("arst_weight", weight_o, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        drain_i = 1'b1; step();
        chk("arst_acc", psum_o, 0);
        chk("arst_drain_valid", psum_valid_o, 1);
`ifdef MAC_PE_SAT_EN
        chk("arst_sat", sat_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_pe_ws.md
Name: mac_pe_ws

Overview:
- Parametrised systolic processing element; successor to the single-weight MAC cell.
- Holds a double-buffered stationary weight and forwards activations east and partial sums south.
- Has two modes: weight-stationary pass-through accumulation, and output-stationary local accumulation with drain.
- Instantiated N×N by the array top. Weights load through a per-column daisy chain.

Parameters:
- DATA_WIDTH, 8, signed activation width.
- WEIGHT_WIDTH, 8, signed weight width.
- ACC_WIDTH, 32, signed partial-sum width; must be ≥ DATA_WIDTH+WEIGHT_WIDTH.
- PIPE_MULT, 0, 1 inserts a product register stage (psum latency +1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global stall; 0 = every register holds
- mode_i  in  1  0 = WS (psum chain), 1 = OS (local accumulate); change only while pipeline empty
- data_i  in  DATA_WIDTH  activation from west
- data_valid_i  in  1  activation valid
- data_o  out  DATA_WIDTH  activation to east, registered
- data_valid_o  out  1  valid to east
- weight_i  in  WEIGHT_WIDTH  weight chain input from north
- weight_load_i  in  1  shift weight_i into shadow register
- weight_o  out  WEIGHT_WIDTH  shadow register, to south PE chain
- weight_load_o  out  1  registered weight_load_i
- weight_swap_i  in  1  copy shadow to active weight
- psum_i  in  ACC_WIDTH  partial sum from north (WS)
- psum_o  out  ACC_WIDTH  partial sum south (WS) / drained accumulator (OS)
- psum_valid_o  out  1  psum_o valid
- acc_clear_i  in  1  OS: next accumulate starts from 0
- drain_i  in  1  OS: present accumulator on psum_o

Behaviour:
- **Reset:** all outputs and registers reset to 0, including shadow weight, active weight and accumulator. Reset is asynchronous and overrides en; reset mid-stream discards in-flight data.
- **Stall:** en=0 freezes all state. Outputs hold their last values and valids are not re-asserted as new events.
- **Forwarding:** when en=1, data_o/data_valid_o <= data_i/data_valid_i (1 cycle).
- **Weight chain:** when en=1, weight_load_o <= weight_load_i. If weight_load_i, shadow <= weight_i. weight_o = shadow.
- **Swap:** if weight_swap_i, active <= shadow.
  - Load+swap in the same cycle: active takes the pre-load shadow.
  - A MAC in the swap cycle uses the old active weight.
- **Product:** p = data_i * active, signed, DATA_WIDTH+WEIGHT_WIDTH bits, sign-extended to ACC_WIDTH. With PIPE_MULT=1, p and its valid are registered first.
- **WS mode:**
  - On product-valid: psum_o <= psum_i + p, psum_valid_o <= 1.
  - Otherwise psum_valid_o <= 0 and psum_o holds.
  - psum_i is sampled in the same cycle as the product is valid (north skew is the array's job).
  - Latency is 1 + PIPE_MULT.
- **OS mode:**
  - On product-valid: acc <= (acc_clear_i ? 0 : acc) + p.
  - acc_clear_i without valid: acc <= 0.
  - drain_i: psum_o <= acc, psum_valid_o <= 1 next cycle.
  - Drain and accumulate in the same cycle: psum_o gets the pre-update acc, and acc still updates.
  - psum_i is ignored.
- **Width:** the sum is formed at ACC_WIDTH+1 bits. Default behaviour is two's-complement wrap to ACC_WIDTH.

Optional Feature:
- Macro: MAC_PE_SAT_EN.
- **Defined:**
  - Each WS/OS sum is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] when the top two bits of the ACC_WIDTH+1 result differ.
  - Adds output port sat_o (1 bit), a sticky flag set on any clamp. It is cleared by rst, or by acc_clear_i in OS mode.
- **Undefined:** wrap arithmetic and no sat_o port.

Decomposition:
- Package systolic_pkg:
  - mode enum pe_mode_e {PE_MODE_WS, PE_MODE_OS}
  - default width localparams
  - function sat_add(a, b) returning the clamped sum and an overflow bit
- One natural sub-module: pe_weight_buf (shadow/active registers, load chain, swap). The MAC datapath stays inline.

Test Plan:
- **Weight chain + swap:** shift 3 then 5 through load over 2 cycles, then swap; weight_o=5 and active=5. A MAC with data 4 in the swap cycle uses the old weight 0 → psum 0.
- **WS basic:** active=-3, data=7, psum_i=100, valid. psum_o=79 after 1 cycle (PIPE_MULT=0) or 2 cycles (PIPE_MULT=1), with psum_valid_o pulsed once.
- **OS accumulate:** active=2, data 1,2,3,4 with clear on the first, then drain → psum_o=20. Drain in the same cycle as a further data=5 → psum_o=20, and a later drain gives 30.
- **Overflow:** ACC_WIDTH=16, psum_i=32760, data=127, w=1 → psum_o=-32649 (wrap). With MAC_PE_SAT_EN → 32767 and sat_o=1.
- **Stall:** en=0 for 3 cycles mid-stream → outputs frozen, no extra valid pulses; results resume identically.
- **Reset:** assert rst asynchronously mid-accumulate → all outputs 0 immediately and acc=0 after release.
